// File: rtl/unmerge32_if.sv
// Stream-side and lane-side signals of the 32-way unmerge unit.
// UNMERGE32_FRAME_COUNT_EN adds the 16-bit frame_count output.
interface unmerge32_if #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32
);
    logic               running;
    logic               run;
    logic [DATA_W-1:0]  in0;
    logic [DELAY_W-1:0] delay0;
    logic [4:0]         lanes0;
    logic [DATA_W-1:0]  out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7;
    logic [DATA_W-1:0]  out8,  out9,  out10, out11, out12, out13, out14, out15;
    logic [DATA_W-1:0]  out16, out17, out18, out19, out20, out21, out22, out23;
    logic [DATA_W-1:0]  out24, out25, out26, out27, out28, out29, out30, out31;
`ifdef UNMERGE32_FRAME_COUNT_EN
    logic [15:0]        frame_count;
`endif
    logic [1:0]         dbg_state;

    modport master (
        output running, run, in0, delay0, lanes0,
        input  out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
        input  out8,  out9,  out10, out11, out12, out13, out14, out15,
        input  out16, out17, out18, out19, out20, out21, out22, out23,
        input  out24, out25, out26, out27, out28, out29, out30, out31,
`ifdef UNMERGE32_FRAME_COUNT_EN
        input  frame_count,
`endif
        input  dbg_state
    );

    modport slave (
        input  running, run, in0, delay0, lanes0,
        output out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
        output out8,  out9,  out10, out11, out12, out13, out14, out15,
        output out16, out17, out18, out19, out20, out21, out22, out23,
        output out24, out25, out26, out27, out28, out29, out30, out31,
`ifdef UNMERGE32_FRAME_COUNT_EN
        output frame_count,
`endif
        output dbg_state
    );
endinterface

// File: rtl/unmerge32.sv
// De-serializes a merged word stream into up to 32 lanes, committing whole frames at once.
// Optional frame counter enabled by defining UNMERGE32_FRAME_COUNT_EN.
module unmerge32 #(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32
) (
    input logic         clk,
    input logic         rst,
    unmerge32_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DELAY_W-1:0] delay;
    logic [4:0]         counter;
    logic [4:0]         lanes_q;
    logic [DATA_W-1:0]  shadow [32];
    logic [DATA_W-1:0]  out_q  [32];
    logic               commit;

    // The unit stays idle after reset until the first run pulse arms it.
    always_comb begin
        state_nxt = state;
        if (bus.run) begin
            state_nxt = (bus.delay0 != '0) ? S_WAIT : S_CAPT;
        end else if (bus.running && state == S_WAIT && delay <= DELAY_W'(1)) begin
            state_nxt = S_CAPT;
        end
    end

    assign commit = !bus.run && bus.running && state == S_CAPT && counter == lanes_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            delay   <= '0;
            counter <= '0;
            lanes_q <= '0;
            for (int k = 0; k < 32; k++) begin
                shadow[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            state <= state_nxt;
            if (bus.run) begin
                delay   <= bus.delay0;
                lanes_q <= bus.lanes0;
                counter <= '0;
            end else if (bus.running) begin
                if (state == S_WAIT) begin
                    if (delay != '0) delay <= delay - DELAY_W'(1);
                end else if (state == S_CAPT) begin
                    if (counter < lanes_q) begin
                        shadow[counter] <= bus.in0;
                        counter         <= counter + 5'd1;
                    end else begin
                        // Final word bypasses the shadow so the commit lands on its capture edge.
                        for (int k = 0; k < 32; k++) begin
                            if (k < int'(lanes_q))       out_q[k] <= shadow[k];
                            else if (k == int'(lanes_q)) out_q[k] <= bus.in0;
                        end
                        counter <= '0;
                    end
                end
            end
        end
    end

`ifdef UNMERGE32_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        frame_count_q <= '0;
        else if (bus.run) frame_count_q <= '0;
        else if (commit)  frame_count_q <= frame_count_q + 16'd1;
    end

    assign bus.frame_count = frame_count_q;
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

    assign bus.dbg_state = state;

    assign bus.out0  = out_q[0];  assign bus.out1  = out_q[1];  assign bus.out2  = out_q[2];  assign bus.out3  = out_q[3];
    assign bus.out4  = out_q[4];  assign bus.out5  = out_q[5];  assign bus.out6  = out_q[6];  assign bus.out7  = out_q[7];
    assign bus.out8  = out_q[8];  assign bus.out9  = out_q[9];  assign bus.out10 = out_q[10]; assign bus.out11 = out_q[11];
    assign bus.out12 = out_q[12]; assign bus.out13 = out_q[13]; assign bus.out14 = out_q[14]; assign bus.out15 = out_q[15];
    assign bus.out16 = out_q[16]; assign bus.out17 = out_q[17]; assign bus.out18 = out_q[18]; assign bus.out19 = out_q[19];
    assign bus.out20 = out_q[20]; assign bus.out21 = out_q[21]; assign bus.out22 = out_q[22]; assign bus.out23 = out_q[23];
    assign bus.out24 = out_q[24]; assign bus.out25 = out_q[25]; assign bus.out26 = out_q[26]; assign bus.out27 = out_q[27];
    assign bus.out28 = out_q[28]; assign bus.out29 = out_q[29]; assign bus.out30 = out_q[30]; assign bus.out31 = out_q[31];
endmodule

// File: tb/tb_unmerge32.sv
// Directed bench for unmerge32: reset, frame capture/commit, delay, freeze, restart, lanes=0, async reset.
module tb_unmerge32;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    logic [31:0] lane     [32];
    logic [31:0] exp_lane [32];

    unmerge32_if #(.DATA_W(32), .DELAY_W(32)) bus ();

    unmerge32 #(.DELAY_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lane[0]  = bus.out0;  assign lane[1]  = bus.out1;  assign lane[2]  = bus.out2;  assign lane[3]  = bus.out3;
    assign lane[4]  = bus.out4;  assign lane[5]  = bus.out5;  assign lane[6]  = bus.out6;  assign lane[7]  = bus.out7;
    assign lane[8]  = bus.out8;  assign lane[9]  = bus.out9;  assign lane[10] = bus.out10; assign lane[11] = bus.out11;
    assign lane[12] = bus.out12; assign lane[13] = bus.out13; assign lane[14] = bus.out14; assign lane[15] = bus.out15;
    assign lane[16] = bus.out16; assign lane[17] = bus.out17; assign lane[18] = bus.out18; assign lane[19] = bus.out19;
    assign lane[20] = bus.out20; assign lane[21] = bus.out21; assign lane[22] = bus.out22; assign lane[23] = bus.out23;
    assign lane[24] = bus.out24; assign lane[25] = bus.out25; assign lane[26] = bus.out26; assign lane[27] = bus.out27;
    assign lane[28] = bus.out28; assign lane[29] = bus.out29; assign lane[30] = bus.out30; assign lane[31] = bus.out31;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        for (int k = 0; k < 32; k++) chk($sformatf("%s out%0d", tag, k), lane[k], exp_lane[k]);
    endtask

    task automatic chk_fc(input string tag, input logic [15:0] exp);
`ifdef UNMERGE32_FRAME_COUNT_EN
        chk(tag, 32'(bus.frame_count), 32'(exp));
`else
        if (exp == 16'hFFFF) $display("frame counter not built (%s)", tag);
`endif
    endtask

    // Run pulse on the next edge; in0 carries junk that must not be captured.
    task automatic run_cfg(input logic [31:0] d, input logic [4:0] l);
        bus.run    = 1'b1;
        bus.delay0 = d;
        bus.lanes0 = l;
        bus.in0    = 32'hDEAD_BEEF;
        tick();
        bus.run    = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst         = 1'b0;
        bus.running = 1'b1;
        bus.run     = 1'b0;
        bus.in0     = '0;
        bus.delay0  = '0;
        bus.lanes0  = '0;
        for (int k = 0; k < 32; k++) exp_lane[k] = '0;

        // Reset values, then 100 idle cycles with a toggling stream and no run.
        #12;
        chk_lanes("reset");
        chk("reset state", 32'(bus.dbg_state), 32'd0);
        chk_fc("reset fc", 16'd0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in0 = (i % 2 == 1) ? 32'hFFFF_FFFF : (32'h1234_5678 ^ i);
            tick();
            if (i % 50 == 49) chk_lanes("idle");
        end
        chk("idle state", 32'(bus.dbg_state), 32'd0);

        // Four-lane frames, no delay: A commits at E4, B at E8.
        run_cfg(32'd0, 5'd3);
        chk("capt state", 32'(bus.dbg_state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            bus.in0 = 32'hA0 + i;
            if (i == 3) chk_lanes("frameA pre");
            tick();
        end
        for (int k = 0; k < 4; k++) exp_lane[k] = 32'hA0 + k;
        chk_lanes("frameA");
        for (int i = 0; i < 4; i++) begin
            bus.in0 = 32'hB0 + i;
            if (i == 3) chk_lanes("frameB pre");
            tick();
        end
        for (int k = 0; k < 4; k++) exp_lane[k] = 32'hB0 + k;
        chk_lanes("frameB");
        chk_fc("fc after B", 16'd2);

        // 32 lanes after a 5-cycle delay; captures start at E6, commit at E37.
        run_cfg(32'd5, 5'd31);
        chk("wait state", 32'(bus.dbg_state), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in0 = 32'hDEAD_0000 + i;
            tick();
        end
        chk("capt after delay", 32'(bus.dbg_state), 32'd2);
        for (int k = 0; k < 32; k++) begin
            bus.in0 = k;
            if (k == 31) chk_lanes("long pre");
            tick();
        end
        for (int k = 0; k < 32; k++) exp_lane[k] = k;
        chk_lanes("long");
        chk_fc("fc long", 16'd1);

        // Same frame with a 3-cycle freeze before word 10.
        run_cfg(32'd5, 5'd31);
        for (int i = 0; i < 5; i++) begin
            bus.in0 = 32'hDEAD_1000 + i;
            tick();
        end
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                bus.running = 1'b0;
                for (int f = 0; f < 3; f++) begin
                    bus.in0 = 32'h0BAD_0000 + f;
                    tick();
                end
                chk("frozen state", 32'(bus.dbg_state), 32'd2);
                bus.running = 1'b1;
            end
            bus.in0 = 32'h100 + k;
            if (k == 31) chk_lanes("freeze pre");
            tick();
        end
        for (int k = 0; k < 32; k++) exp_lane[k] = 32'h100 + k;
        chk_lanes("freeze");
        chk_fc("fc freeze", 16'd1);

        // Restart after two captures: the partial frame never reaches the lanes.
        run_cfg(32'd0, 5'd3);
        bus.in0 = 32'hC0; tick();
        bus.in0 = 32'hC1; tick();
        run_cfg(32'd0, 5'd3);
        chk_lanes("restart hold");
        for (int i = 0; i < 4; i++) begin
            bus.in0 = 32'hD0 + i;
            if (i == 3) chk_lanes("restart pre");
            tick();
        end
        for (int k = 0; k < 4; k++) exp_lane[k] = 32'hD0 + k;
        chk_lanes("restart");
        chk_fc("fc restart", 16'd1);

        // lanes=0 is a plain register on out0; lanes0 changes without run are ignored.
        run_cfg(32'd0, 5'd0);
        bus.in0 = 32'h11; tick();
        exp_lane[0] = 32'h11;
        chk("l0 first", lane[0], exp_lane[0]);
        bus.lanes0 = 5'd5;
        bus.in0    = 32'h22; tick();
        exp_lane[0] = 32'h22;
        chk_lanes("l0 second");
        chk_fc("fc l0", 16'd2);

        // Fill all lanes with 0x55, start a new frame, then drop reset between edges.
        run_cfg(32'd0, 5'd31);
        for (int k = 0; k < 32; k++) begin
            bus.in0 = 32'h55;
            tick();
        end
        for (int k = 0; k < 32; k++) exp_lane[k] = 32'h55;
        chk_lanes("fill55");
        for (int k = 0; k < 5; k++) begin
            bus.in0 = 32'h66;
            tick();
        end
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) exp_lane[k] = '0;
        chk_lanes("async rst");
        chk_fc("fc async rst", 16'd0);
        chk("rst state", 32'(bus.dbg_state), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in0 = 32'hF0F0_0000 + i;
            tick();
        end
        chk_lanes("post rst idle");
        chk("post rst state", 32'(bus.dbg_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
